jt49_chmix: RTL and testbench
=============================

# jt49_chmix

Sequential three-channel mixer for the JT49 PSG audio path. It snapshots the three unsigned channel amplitudes on each sample strobe and applies a per-channel 4-bit gain using a single time-shared multiply-accumulate. It then scales and saturates the sum to an unsigned `sw`-bit sample. Its output `dout` feeds the unsigned `din` of the downstream DC-removal filter, which consumes one sample per `cen`.

## Interface
- `sw`, default 8: channel and output sample width, unsigned.
- `gsh`, default 2: right-shift applied to the accumulated sum, so gain step = 1/2^gsh.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `cen`  in  1  sample strobe: one-`clk`-wide pulse requesting a new mix.
- `ch_a`, `ch_b`, `ch_c`  in  `sw` each  unsigned channel amplitudes.
- `gain_a`, `gain_b`, `gain_c`  in  4 each  unsigned per-channel gain, 0..15.
- `dout`  out  `sw`  unsigned mixed sample, held between updates.
- `dout_vld`  out  1  one-`clk` pulse when `dout` updates.
- `busy`  out  1  high while a mix is in progress (state ≠ IDLE).
- `overrun`  out  1  sticky flag: a `cen` arrived while busy; cleared only by `rst`.

## Operation
- FSM states: IDLE → MA → MB → MC → OUT → IDLE. It advances every `clk`; only the IDLE exit waits for `cen`.
- **IDLE with `cen`=1:**
  - capture `ch_*` and `gain_*` into snapshot registers
  - clear the accumulator `acc`
  - go to MA
- **MA:** `acc += ch_a_s * gain_a_s`; go to MB.
- **MB:** `acc += ch_b_s * gain_b_s`; go to MC.
- **MC:** `acc += ch_c_s * gain_c_s`; go to OUT.
- **OUT:** `dout <= sat(acc >> gsh)`; `dout_vld <= 1`; go to IDLE.
- Use one shared `sw`×4 multiplier, selected by state. Each product is `sw+4` bits.
- `acc` is `sw+6` bits wide (3·255·15 = 11475 fits in 14 bits for sw=8). The accumulator never wraps.
- Shift is a logical right shift by `gsh` and truncates (no rounding).
- Saturation: if the shifted value is ≥ 2^sw, `dout` = all ones; otherwise `dout` = the low `sw` bits.
- `cen` in any state other than IDLE is ignored: the mix in flight is unaffected, and `overrun` is set to 1.
- Inputs `ch_*`/`gain_*` may change freely after the capture edge; only the snapshot is used.
- Gain 0 mutes that channel. All gains 0 gives `dout` = 0, and `dout_vld` still pulses.

## Timing
- Reset values: `dout`=0, `dout_vld`=0, `busy`=0, `overrun`=0; state = IDLE; `acc` and all snapshot registers = 0.
- `rst` mid-mix aborts the mix: no `dout_vld`, and `dout` returns to 0 at that edge.
- `rst` has priority over `cen` at the same edge.
- Latency, counting the edge where `cen` is sampled high in IDLE as E0:
  - E0: capture inputs.
  - E1, E2, E3: MAC steps.
  - E4: `dout` and `dout_vld` register.
  - `dout_vld` is high for the cycle after E4 and low again after E5.
- `busy` is high from after E0 until after E4, i.e. 4 cycles.
- Minimum `cen` spacing is 5 clocks:
  - a `cen` at E5 is accepted;
  - a `cen` at E1..E4 is dropped and sets `overrun`.
- `dout` is stable between consecutive `dout_vld` pulses. The downstream `cen` can be the same strobe, which then consumes the previous sample.

## Test plan
- **Reset:** assert `rst` 3 clocks with `cen` pulsing → `dout`=0, `dout_vld`=0, `busy`=0, `overrun`=0 throughout.
- **Basic mix:** `ch_a`=100, `gain_a`=4, other gains 0, `cen` pulse → `dout_vld` exactly 4 clocks after the `cen` edge, `dout`=100. Separately, `ch_*`=10/10/10, gains 1/1/2 → `dout`=10.
- **Saturation and truncation:** all `ch`=255, all gains 15 → 11475>>2 = 2868, so `dout`=255. Then `ch_a`=3, `gain_a`=1, others 0 → `dout`=0.
- **Snapshot:** `ch_a`=200, `gain_a`=4 at `cen`, then change `ch_a` to 0 on the next clock → `dout`=200.
- **Overrun:** `cen` at E0 and again at E2 → only one `dout_vld`, `overrun`=1 and held. Next `cen` at E5 → accepted, with a second `dout_vld` at E9.
- **Reset mid-operation:** `rst` at E2 → no `dout_vld`, `dout`=0, state IDLE. A `cen` one clock after reset deasserts gives a correct result.

Source files
------------

// File: rtl/jt49_chmix.sv
// Three-channel PSG mixer: snapshot on cen, one shared multiplier walks the
// channels in turn, then the sum is shifted and saturated to an sw-bit sample.
module jt49_chmix #(
    parameter int sw  = 8,
    parameter int gsh = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [sw-1:0] ch_a,
    input  logic [sw-1:0] ch_b,
    input  logic [sw-1:0] ch_c,
    input  logic [3:0]    gain_a,
    input  logic [3:0]    gain_b,
    input  logic [3:0]    gain_c,
    output logic [sw-1:0] dout,
    output logic          dout_vld,
    output logic          busy,
    output logic          overrun,
    output logic [2:0]    fsm_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MA   = 3'd1,
        MB   = 3'd2,
        MC   = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [sw-1:0] ch_a_s, ch_b_s, ch_c_s;
    logic [3:0]    gain_a_s, gain_b_s, gain_c_s;
    logic [sw+5:0] acc;
    logic [sw-1:0] mul_ch;
    logic [3:0]    mul_g;
    logic [sw+3:0] prod;
    logic [sw+5:0] shifted;
    logic [sw-1:0] sat_val;
    logic          start;
    logic          mac_en;

    // cen handshake: a strobe is taken only in IDLE; anywhere else it is
    // dropped and recorded in the sticky overrun flag.
    assign start  = cen && (state == IDLE);
    assign mac_en = (state == MA) || (state == MB) || (state == MC);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cen) state_nxt = MA;
            MA:      state_nxt = MB;
            MB:      state_nxt = MC;
            MC:      state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mul_ch = '0;
        mul_g  = '0;
        case (state)
            MA: begin mul_ch = ch_a_s; mul_g = gain_a_s; end
            MB: begin mul_ch = ch_b_s; mul_g = gain_b_s; end
            MC: begin mul_ch = ch_c_s; mul_g = gain_c_s; end
            default: begin mul_ch = '0; mul_g = '0; end
        endcase
    end

    assign prod    = {4'b0, mul_ch} * {{sw{1'b0}}, mul_g};
    assign shifted = acc >> gsh;
    assign sat_val = (|shifted[sw+5:sw]) ? {sw{1'b1}} : shifted[sw-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_a_s   <= '0;
            ch_b_s   <= '0;
            ch_c_s   <= '0;
            gain_a_s <= '0;
            gain_b_s <= '0;
            gain_c_s <= '0;
            acc      <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            dout_vld <= 1'b0;
            if (start) begin
                ch_a_s   <= ch_a;
                ch_b_s   <= ch_b;
                ch_c_s   <= ch_c;
                gain_a_s <= gain_a;
                gain_b_s <= gain_b;
                gain_c_s <= gain_c;
                acc      <= '0;
            end else if (mac_en) begin
                acc <= acc + {2'b0, prod};
            end
            if (state == OUT) begin
                dout     <= sat_val;
                dout_vld <= 1'b1;
            end
            if (cen && (state != IDLE)) overrun <= 1'b1;
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_jt49_chmix.sv
// Bench for jt49_chmix: directed scenarios plus random traffic, all checked
// against a cycle-count model of the mixer.
module tb_jt49_chmix;
    localparam int SW  = 8;
    localparam int GSH = 2;
    localparam int MAXV = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen = 1'b0;
    logic [SW-1:0] ch_a = '0, ch_b = '0, ch_c = '0;
    logic [3:0]    gain_a = '0, gain_b = '0, gain_c = '0;
    logic [SW-1:0] dout;
    logic          dout_vld;
    logic          busy;
    logic          overrun;
    logic [2:0]    fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    int vld_count = 0;

    // reference model state
    int m_left = 0;
    int m_pending = 0;
    int m_dout = 0;
    int m_vld = 0;
    int m_ovr = 0;

    always #5 clk = ~clk;

    jt49_chmix #(.sw(SW), .gsh(GSH)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c),
        .gain_a(gain_a), .gain_b(gain_b), .gain_c(gain_c),
        .dout(dout), .dout_vld(dout_vld), .busy(busy),
        .overrun(overrun), .fsm_state(fsm_state)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int mix(input int a, b, c, ga, gb, gc);
        int s;
        s = (a * ga + b * gb + c * gc) / (1 << GSH);
        if (s > MAXV) s = MAXV;
        return s;
    endfunction

    // One clock: the model digests the inputs seen at this edge, then the
    // DUT outputs are compared just after it.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_left = 0; m_dout = 0; m_vld = 0; m_ovr = 0;
        end else begin
            m_vld = 0;
            if (m_left > 0) begin
                if (cen) m_ovr = 1;
                m_left--;
                if (m_left == 0) begin
                    m_dout = m_pending;
                    m_vld = 1;
                end
            end else if (cen) begin
                m_pending = mix(ch_a, ch_b, ch_c, gain_a, gain_b, gain_c);
                m_left = 4;
            end
        end
        #1;
        if (dout_vld) vld_count++;
        check("dout", dout, m_dout);
        check("dout_vld", dout_vld, m_vld);
        check("busy", busy, (m_left > 0) ? 1 : 0);
        check("overrun", overrun, m_ovr);
    endtask

    task automatic set_in(input int a, b, c, ga, gb, gc);
        ch_a = a; ch_b = b; ch_c = c;
        gain_a = ga; gain_b = gb; gain_c = gc;
    endtask

    // cen for one cycle, then idle until the sample lands
    task automatic run_mix(input string tag, input int exp);
        int v0;
        v0 = vld_count;
        cen = 1'b1; step(); cen = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check({tag, "_vld_cnt"}, vld_count - v0, 1);
        check({tag, "_val"}, dout, exp);
    endtask

    initial begin
        // reset held 3 clocks with cen toggling
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cen = 1'b1; step();
        end
        check("rst_state_idle", fsm_state, 0);
        cen = 1'b0; rst = 1'b0;
        step();

        set_in(100, 0, 0, 4, 0, 0);
        run_mix("basic_a", 100);
        set_in(10, 10, 10, 1, 1, 2);
        run_mix("basic_abc", 10);
        set_in(255, 255, 255, 15, 15, 15);
        run_mix("saturate", 255);
        set_in(3, 0, 0, 1, 0, 0);
        run_mix("truncate", 0);
        set_in(77, 88, 99, 0, 0, 0);
        run_mix("all_mute", 0);

        // snapshot: input changes right after capture
        set_in(200, 0, 0, 4, 0, 0);
        cen = 1'b1; step(); cen = 1'b0;
        ch_a = 0;
        for (int i = 0; i < 5; i++) step();
        check("snapshot", dout, 200);

        // overrun: cen at E0, E2, then E5
        set_in(40, 20, 0, 2, 3, 0);
        vld_count = 0;
        cen = 1'b1; step();               // E0
        cen = 1'b0; step();               // E1
        cen = 1'b1; set_in(1, 1, 1, 1, 1, 1); step(); // E2 dropped
        cen = 1'b0; step(); step();       // E3 E4
        check("ovr_first_val", dout, 35);
        check("ovr_flag", overrun, 1);
        set_in(60, 0, 0, 8, 0, 0);
        cen = 1'b1; step();               // E5 accepted
        cen = 1'b0;
        for (int i = 0; i < 4; i++) step(); // E6..E9
        check("ovr_second_vld", dout_vld, 1);
        check("ovr_second_val", dout, 120);
        check("ovr_vld_total", vld_count, 2);
        check("ovr_held", overrun, 1);

        // reset mid-mix at E2
        set_in(250, 250, 0, 9, 9, 0);
        vld_count = 0;
        cen = 1'b1; step(); cen = 1'b0;   // E0
        step();                           // E1
        rst = 1'b1; step();               // E2
        check("midrst_state", fsm_state, 0);
        check("midrst_dout", dout, 0);
        rst = 1'b0; step(); step();
        check("midrst_no_vld", vld_count, 0);
        set_in(12, 34, 56, 3, 5, 7);
        run_mix("post_rst", mix(12, 34, 56, 3, 5, 7));

        // random traffic with occasional reset
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            cen = ($urandom_range(0, 3) == 0);
            set_in($urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, MAXV),
                   $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            step();
        end
        rst = 1'b0; cen = 1'b0;
        for (int i = 0; i < 6; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
